// File: rtl/mem_checker_pkg.sv
// Shared types and saturation helpers for the end-of-run memory checker.
// Optional run timeout is enabled with `define CHECKER_TIMEOUT_EN.
package mem_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_CHECK,
    ST_REPORT,
    ST_END
  } state_e;

  function automatic logic [31:0] sat_max(
    input int unsigned w
  );
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] max;
    max = sat_max(w);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_checker_if.sv
// Snoop, preload and PC bus observed by the memory checker.
// The bench side drives it (master); the checker only listens (slave).
interface mem_checker_if
  import mem_checker_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int N_CH   = 2
);

  logic [N_CH-1:0]        wen;
  logic [N_CH*ADDR_W-1:0] waddr;
  logic [N_CH*DATA_W-1:0] wdata;
  logic                   ld_wen;
  logic                   ld_sel;
  logic [ADDR_W-1:0]      ld_addr;
  logic [DATA_W-1:0]      ld_wdata;
  logic [31:0]            pc;

  modport master (
    output wen, waddr, wdata,
    output ld_wen, ld_sel,
    output ld_addr, ld_wdata,
    output pc
  );

  modport slave (
    input wen, waddr, wdata,
    input ld_wen, ld_sel,
    input ld_addr, ld_wdata,
    input pc
  );

endinterface

// File: rtl/checker_shadow_mem.sv
// Word memory with prioritised write ports (highest index wins),
// a global write gate and one combinational read port.
module checker_shadow_mem
  import mem_checker_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int N_PORT = 3
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [N_PORT-1:0]        we,
  input  logic [N_PORT*ADDR_W-1:0] addr,
  input  logic [N_PORT*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // later ports overwrite earlier ones within the same edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < N_PORT; i++) begin
        if (we[i]) begin
          mem_q[addr[i*ADDR_W +: ADDR_W]] <=
            wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_result_checker.sv
// End-of-run checker: snoops writes, sweeps shadow vs golden, reports.
// Optional run timeout is enabled with `define CHECKER_TIMEOUT_EN.
module mem_result_checker
  import mem_checker_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              DATA_W      = 32,
  parameter int              N_CH        = 2,
  parameter int              ERR_W       = 9,
  parameter int              CYC_W       = 24,
  parameter logic [31:0]     END_PC      = 32'd400,
  parameter logic [CYC_W-1:0] TIMEOUT_CYC = CYC_W'(10000000)
) (
  input  logic              clk,
  input  logic              rst,
  mem_checker_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_num,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [CYC_W-1:0]  duration,
  output logic              timeout
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CYC_W-1:0] TO_LAST =
    TIMEOUT_CYC - CYC_W'(1);
`ifdef CHECKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fev_q, fev_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [CYC_W-1:0]  dur_q, dur_d;
  logic              to_q, to_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wr_en;
  logic              pc_hit;
  logic              to_hit;
  logic [DATA_W-1:0] sh_rd;
  logic [DATA_W-1:0] gd_rd;

  assign wr_en  = (state_q == ST_RUN);
  assign pc_hit = (bus.pc >= END_PC);
  assign to_hit = TO_EN && (dur_q == TO_LAST);

  // port 0 is the preload path, ports 1..N_CH the snooped channels
  checker_shadow_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_PORT (N_CH + 1)
  ) u_shadow (
    .clk   (clk),
    .wr_en (wr_en),
    .we    ({bus.wen, bus.ld_wen & ~bus.ld_sel}),
    .addr  ({bus.waddr, bus.ld_addr}),
    .wdata ({bus.wdata, bus.ld_wdata}),
    .raddr (cnt_q),
    .rdata (sh_rd)
  );

  checker_shadow_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_PORT (1)
  ) u_golden (
    .clk   (clk),
    .wr_en (wr_en),
    .we    (bus.ld_wen & bus.ld_sel),
    .addr  (bus.ld_addr),
    .wdata (bus.ld_wdata),
    .raddr (cnt_q),
    .rdata (gd_rd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    dur_d   = dur_q;
    to_d    = to_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_RUN: begin
        if (pc_hit) begin
          state_d = ST_CHECK;
        end else if (to_hit) begin
          state_d = ST_REPORT;
          to_d    = 1'b1;
        end else begin
          dur_d = CYC_W'(sat_inc(32'(dur_q), CYC_W));
        end
      end
      ST_CHECK: begin
        if (sh_rd != gd_rd) begin
          err_d = ERR_W'(sat_inc(32'(err_q), ERR_W));
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = cnt_q;
          end
        end
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        pass_d  = (err_q == '0) && !to_q;
        state_d = ST_END;
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_CHECK) ||
             (state_d == ST_REPORT);
    done_d = (state_d == ST_END);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      dur_q   <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      dur_q   <= dur_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_num       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;
  assign duration        = dur_q;
  assign timeout         = to_q;

endmodule

// File: doc/mem_result_checker.md
# mem_result_checker

Parametrised end-of-run memory checker for the processor/cache testbench. It snoops every data-cache write port into a shadow memory and holds a preloaded golden image. Once the processor PC reaches a configured end address, it sweeps both memories word by word and reports mismatch count, first failing address, run duration and a pass/done verdict. It is the multi-channel, synthesizable successor to the single-port testbed checker, and sits beside CHIP in the top-level bench.

## Interface
Parameters:
- ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W words
- DATA_W, 32, word width
- N_CH, 2, number of snooped write channels
- ERR_W, 9, error counter width (saturating)
- CYC_W, 24, duration counter width (saturating)
- END_PC, 400, PC threshold that ends the run
- TIMEOUT_CYC, 10000000 truncated to CYC_W, run-cycle limit (used only with CHECKER_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- wen  in  N_CH  per-channel snoop write enable
- waddr  in  N_CH*ADDR_W  per-channel word address; channel i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_CH*DATA_W  per-channel write data
- ld_wen  in  1  preload write enable
- ld_sel  in  1  preload target: 0 = shadow, 1 = golden
- ld_addr  in  ADDR_W  preload address
- ld_wdata  in  DATA_W  preload data
- pc  in  32  processor PC
- busy  out  1  high in CHECK or REPORT
- done  out  1  high in END
- pass  out  1  valid when done; 1 iff error_num==0 and no timeout
- error_num  out  ERR_W  mismatch count
- first_err_valid  out  1  a mismatch has been captured
- first_err_addr  out  ADDR_W  address of the first mismatch
- duration  out  CYC_W  RUN cycles elapsed
- timeout  out  1  run aborted by timeout

## Operation
- States: RUN (reset state), CHECK, REPORT, END.
- RUN:
  - Snoop and preload writes are accepted. Shadow write priority at the same address: highest channel index wins over lower channels, which win over preload.
  - duration increments every cycle and saturates at all-ones.
  - RUN→CHECK when the unsigned comparison pc >= END_PC is true at a clock edge.
- CHECK:
  - A counter cnt runs 0..DEPTH-1, one word per cycle. shadow[cnt] !== golden[cnt] increments error_num, saturating at 2**ERR_W-1.
  - The first mismatch latches first_err_addr=cnt and sets first_err_valid.
  - CHECK→REPORT in the cycle cnt==DEPTH-1 is compared.
- REPORT: computes pass, then goes to END unconditionally.
- END: terminal state until reset; done=1, pass held.
- All writes (snoop and preload) are ignored outside RUN. The memories freeze at CHECK entry.
- Reset values: busy=0, done=0, pass=0, error_num=0, first_err_valid=0, first_err_addr=0, duration=0, timeout=0, cnt=0, state=RUN. Memory contents are not reset.
- Reset asserted mid-CHECK aborts immediately; the next run restarts in RUN with the memory contents kept.

## Timing
- Snoop/preload write visible in memory the cycle after the edge.
- PC condition sampled at edge k → CHECK from k; last compare at k+DEPTH-1; REPORT at k+DEPTH; done=1 after edge k+DEPTH+1.
- Total check latency: DEPTH+2 cycles.
- error_num and first_err_* update one edge after the compare cycle.
- duration stops at CHECK entry.

## Configuration
- CHECKER_TIMEOUT_EN:
  - Defined: in RUN, when duration == TIMEOUT_CYC-1 and the PC condition is false, go to REPORT directly (no sweep) and set timeout=1, giving pass=0 and done=1.
  - PC condition and timeout in the same cycle: the PC condition wins.
  - Undefined: no timeout logic; timeout output tied 0.

## Structure
- Package mem_checker_pkg: state enum (RUN, CHECK, REPORT, END) and the ERR_W/CYC_W saturation helpers.
- Sub-module checker_shadow_mem: DEPTH×DATA_W storage with N_CH+1 prioritised write ports, a write-enable gate and one combinational read port. It is instantiated twice, for shadow (N_CH+1 ports) and golden (preload only).
- The FSM, counters and verdict logic live in the top module.

## Test plan
- Preload golden = shadow = 0..255; no snoop writes; pc=400 at cycle 10 → done after 258 cycles, error_num=0, pass=1.
- Same setup, ch0 writes addr 5=0xDEAD and ch1 writes addr 200=0x1 → error_num=2, first_err_addr=5, pass=0.
- ch0 and ch1 both write addr 7 in the same cycle (0xA, 0xB), golden[7]=0xB → no error at 7.
- Golden all zeros, shadow all ones, ERR_W=4 → error_num saturates at 15, first_err_addr=0.
- Snoop write issued during CHECK to a mismatching address → ignored, count unchanged; reset asserted mid-CHECK → all outputs 0 within the same cycle.
- With CHECKER_TIMEOUT_EN and TIMEOUT_CYC=100, pc held at 0 → timeout=1, done=1, pass=0, duration=99; without the macro → never done.
